jtframe_rom_arb2: RTL and testbench

Two-port arbiter that shares one SDRAM ROM slot between two CPU-side requesters, typically two Z80s on the same game ROM. Each port has a one-entry address/data cache, and the block runs round-robin scheduling of misses onto the single slot. Each port's `rom_cs`/`rom_ok` pair drives its own wait-state/clock-gating block, so a CPU stalls only while its own fetch is outstanding.

---
 rtl/jtframe_rom_arb2.sv | 133 +++++++++++++
 tb/tb_jtframe_rom_arb2.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_arb2.sv
// Two-port ROM arbiter: one-entry address/data cache per port, with cache
// misses served round-robin through a single registered SDRAM slot.
//
// state | meaning
// IDLE  | no access in flight; grant a pending port (ties go to !last_gnt)
// WAIT  | slot_cs high; the first cycle ignores a possibly stale slot_ok
// GAP   | slot_cs low for one cycle so the slot sees a cs falling edge
module jtframe_rom_arb2 #(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [1:0]      req_cs,
  input  logic [2*AW-1:0] req_addr,
  output logic [1:0]      req_ok,
  output logic [2*DW-1:0] req_dout,
  output logic            slot_cs,
  output logic [AW-1:0]   slot_addr,
  input  logic            slot_ok,
  input  logic [DW-1:0]   slot_din
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  fresh_q, fresh_d;
  logic                  drop_q, drop_d;
  logic                  slot_cs_q, slot_cs_d;
  logic [AW-1:0]         slot_addr_q, slot_addr_d;
  logic [1:0][AW-1:0]    tag_q, tag_d;
  logic [1:0][DW-1:0]    data_q, data_d;
  logic [1:0]            valid_q, valid_d;

  logic [1:0][AW-1:0]    addr;
  logic [1:0]            hit;
  logic [1:0]            pend;
  logic                  grant_sel;
  logic                  fill;

  assign addr      = req_addr;
  assign hit[0]    = valid_q[0] && (tag_q[0] == addr[0]);
  assign hit[1]    = valid_q[1] && (tag_q[1] == addr[1]);
  assign pend      = req_cs & ~hit;
  assign req_ok    = req_cs & hit;
  assign req_dout  = data_q;
  assign slot_cs   = slot_cs_q;
  assign slot_addr = slot_addr_q;

  assign grant_sel = (pend == 2'b11) ? ~last_gnt_q : pend[1];
  assign fill      = (state_q == ST_WAIT) && slot_ok && !fresh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      fresh_q     <= 1'b0;
      drop_q      <= 1'b0;
      slot_cs_q   <= 1'b0;
      slot_addr_q <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      valid_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      fresh_q     <= fresh_d;
      drop_q      <= drop_d;
      slot_cs_q   <= slot_cs_d;
      slot_addr_q <= slot_addr_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pend != 2'b00) state_d = ST_WAIT;
      ST_WAIT: if (fill) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    fresh_d     = fresh_q;
    drop_d      = drop_q;
    slot_cs_d   = slot_cs_q;
    slot_addr_d = slot_addr_q;
    tag_d       = tag_q;
    data_d      = data_q;
    valid_d     = valid_q;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (pend != 2'b00) begin
          gnt_d       = grant_sel;
          last_gnt_d  = grant_sel;
          slot_addr_d = addr[grant_sel];
          slot_cs_d   = 1'b1;
          fresh_d     = 1'b1;
        end
      end
      ST_WAIT: begin
        fresh_d = 1'b0;
        if (flush) drop_d = 1'b1;
        // The fill always lands for the address that was issued, even if
        // the requester has since moved on or been flushed.
        if (fill) begin
          tag_d[gnt_q]   = slot_addr_q;
          data_d[gnt_q]  = slot_din;
          valid_d[gnt_q] = !drop_q;
          slot_cs_d      = 1'b0;
        end
      end
      default: begin
        slot_cs_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
    if (flush) valid_d = 2'b00;
  end

endmodule

// File: tb/tb_jtframe_rom_arb2.sv
// Bench for jtframe_rom_arb2: directed transaction table, multi-cycle corner
// sequences, and a randomized phase checked against a memory/liveness model.
module tb_jtframe_rom_arb2;
  localparam int AW = 17;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      req_cs = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [1:0]      req_ok;
  logic [2*DW-1:0] req_dout;
  logic            slot_cs;
  logic [AW-1:0]   slot_addr;
  logic            slot_ok = 1'b0;
  logic [DW-1:0]   slot_din = '0;

  int n_vec = 0;
  int n_err = 0;

  int sd_lat = 1;
  bit sd_stale = 1'b0;
  int sd_cnt = 0;
  int hi_run = 0, last_hi = 0, min_hi = 1000, n_access = 0, addr_moves = 0;
  logic prev_cs = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int dat_checks = 0, dat_bad = 0;

  jtframe_rom_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_cs    (req_cs),
    .req_addr  (req_addr),
    .req_ok    (req_ok),
    .req_dout  (req_dout),
    .slot_cs   (slot_cs),
    .slot_addr (slot_addr),
    .slot_ok   (slot_ok),
    .slot_din  (slot_din)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h86;
  endfunction

  // SDRAM model: data valid sd_lat cycles after cs rises; data bus holds the
  // previous word until then. In stale mode slot_ok never drops.
  always @(posedge clk) begin
    #1;
    if (slot_cs) sd_cnt++; else sd_cnt = 0;
    slot_ok = sd_stale || (slot_cs && sd_cnt > sd_lat);
    if (slot_cs && sd_cnt > sd_lat) slot_din = mem(slot_addr);
    if (slot_cs && !prev_cs) n_access++;
    if (slot_cs && prev_cs && slot_addr != prev_addr) addr_moves++;
    if (slot_cs) hi_run++;
    else if (prev_cs) begin
      last_hi = hi_run;
      if (rst_n && hi_run < min_hi) min_hi = hi_run;
      hi_run = 0;
    end
    prev_cs   = slot_cs;
    prev_addr = slot_addr;
  end

  // Any port reporting ok must show the memory word for its present address.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (req_ok[i]) begin
        dat_checks++;
        if (req_dout[i*DW +: DW] !== mem(req_addr[i*AW +: AW])) dat_bad++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wait_ok(input int p, input int maxc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (req_ok[p]) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic wait_cs(input logic v, input int maxc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (slot_cs == v) begin
        cyc = c;
        break;
      end
    end
  endtask

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    int            lat;
    int            hi;
    logic [DW-1:0] dout;
  } txn_t;

  txn_t tbl[4];

  initial begin
    int cyc;
    int acc0;
    int wc[2];
    logic [AW-1:0] pa[2];

    tbl[0] = '{0, 17'h00123, 3, 4, 8'hA5};
    tbl[1] = '{1, 17'h00077, 1, 2, 8'hF1};
    tbl[2] = '{0, 17'h1FFFF, 5, 6, 8'h79};
    tbl[3] = '{1, 17'h00000, 2, 3, 8'h86};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ok", req_ok, 0);
    chk("rst_req_dout", req_dout, 0);
    chk("rst_slot_cs", slot_cs, 0);
    chk("rst_slot_addr", slot_addr, 0);
    rst_n = 1'b1;

    foreach (tbl[t]) begin
      @(posedge clk); #1;
      sd_lat = tbl[t].lat;
      acc0 = n_access;
      req_cs = 2'b00;
      req_cs[tbl[t].port] = 1'b1;
      req_addr[tbl[t].port*AW +: AW] = tbl[t].addr;
      wait_ok(tbl[t].port, 40, cyc);
      chk($sformatf("t%0d_latency", t), cyc, tbl[t].hi + 2);
      chk($sformatf("t%0d_slot_addr", t), slot_addr, tbl[t].addr);
      chk($sformatf("t%0d_cs_high", t), last_hi, tbl[t].hi);
      chk($sformatf("t%0d_dout", t), req_dout[tbl[t].port*DW +: DW], tbl[t].dout);
      chk($sformatf("t%0d_accesses", t), n_access - acc0, 1);
      @(posedge clk); #1;
      req_cs = 2'b00;
      @(posedge clk); #1;
      req_cs[tbl[t].port] = 1'b1;
      #1;
      chk($sformatf("t%0d_hit_ok", t), req_ok[tbl[t].port], 1);
      repeat (4) @(posedge clk);
      chk($sformatf("t%0d_hit_no_access", t), n_access - acc0, 1);
      #1;
      req_cs = 2'b00;
    end

    // Tie: port 1 was granted last, so port 0 goes first.
    @(posedge clk); #1;
    sd_lat = 2;
    acc0 = n_access;
    req_addr = {17'h00020, 17'h00010};
    req_cs = 2'b11;
    @(negedge clk); @(negedge clk);
    chk("tie1_first_cs", slot_cs, 1);
    chk("tie1_first_addr", slot_addr, 17'h00010);
    wait_ok(0, 20, cyc);
    chk("tie1_p0_lat", cyc, 3);
    chk("tie1_p1_not_ok", req_ok[1], 0);
    @(negedge clk);
    chk("tie1_gap_cs", slot_cs, 0);
    @(negedge clk);
    chk("tie1_second_cs", slot_cs, 1);
    chk("tie1_second_addr", slot_addr, 17'h00020);
    wait_ok(1, 20, cyc);
    chk("tie1_p1_lat", cyc, 3);
    chk("tie1_dout1", req_dout[DW +: DW], 8'hA6);
    chk("tie1_dout0", req_dout[0 +: DW], 8'h96);
    chk("tie1_both_ok", req_ok, 2'b11);
    chk("tie1_accesses", n_access - acc0, 2);

    @(posedge clk); #1;
    req_cs = 2'b01;
    req_addr[0 +: AW] = 17'h00050;
    wait_ok(0, 20, cyc);
    chk("single_p0_done", cyc > 0, 1);
    chk("single_p0_dout", req_dout[0 +: DW], 8'hD6);

    // Second tie after a port-0 grant: port 1 goes first.
    @(posedge clk); #1;
    req_addr = {17'h00061, 17'h00060};
    req_cs = 2'b11;
    @(negedge clk); @(negedge clk);
    chk("tie2_first_cs", slot_cs, 1);
    chk("tie2_first_addr", slot_addr, 17'h00061);
    wait_ok(1, 20, cyc);
    chk("tie2_p1_done", cyc > 0, 1);
    wait_ok(0, 20, cyc);
    chk("tie2_p0_done", cyc > 0, 1);
    chk("tie2_dout1", req_dout[DW +: DW], 8'hE7);
    chk("tie2_dout0", req_dout[0 +: DW], 8'hE6);

    // slot_ok stuck high.
    @(posedge clk); #1;
    req_cs = 2'b00;
    sd_stale = 1'b1;
    sd_lat = 1;
    @(posedge clk); #1;
    req_addr[0 +: AW] = 17'h00ABC;
    req_cs = 2'b01;
    wait_ok(0, 20, cyc);
    chk("stale_p0_lat", cyc, 4);
    chk("stale_p0_cs_high", last_hi, 2);
    chk("stale_p0_dout", req_dout[0 +: DW], 8'h3A);
    @(posedge clk); #1;
    req_addr[AW +: AW] = 17'h00055;
    req_cs = 2'b10;
    wait_ok(1, 20, cyc);
    chk("stale_p1_lat", cyc, 4);
    chk("stale_p1_cs_high", last_hi, 2);
    chk("stale_p1_dout", req_dout[DW +: DW], 8'hD3);
    @(posedge clk); #1;
    req_cs = 2'b00;
    sd_stale = 1'b0;

    // Address change while the slot access is in flight.
    repeat (2) @(posedge clk);
    #1;
    sd_lat = 3;
    acc0 = n_access;
    req_addr[0 +: AW] = 17'h00040;
    req_cs = 2'b01;
    @(negedge clk); @(negedge clk);
    chk("ac_cs_up", slot_cs, 1);
    @(posedge clk); #1;
    req_addr[0 +: AW] = 17'h00041;
    wait_cs(1'b0, 20, cyc);
    chk("ac_fill_cyc", cyc, 4);
    chk("ac_ok_low", req_ok[0], 0);
    chk("ac_dout_old", req_dout[0 +: DW], 8'hC6);
    chk("ac_slot_addr_old", slot_addr, 17'h00040);
    @(negedge clk);
    chk("ac_gap_cs", slot_cs, 0);
    @(negedge clk);
    chk("ac_refetch_cs", slot_cs, 1);
    chk("ac_refetch_addr", slot_addr, 17'h00041);
    wait_ok(0, 20, cyc);
    chk("ac_refetch_lat", cyc, 4);
    chk("ac_dout_new", req_dout[0 +: DW], 8'hC7);
    chk("ac_accesses", n_access - acc0, 2);

    // Flush in the middle of WAIT.
    @(posedge clk); #1;
    req_addr[AW +: AW] = 17'h00099;
    req_cs = 2'b10;
    @(negedge clk); @(negedge clk);
    chk("fl_cs_up", slot_cs, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_cs(1'b0, 20, cyc);
    chk("fl_fill_cyc", cyc, 3);
    chk("fl_ok_low", req_ok[1], 0);
    chk("fl_dout", req_dout[DW +: DW], 8'h1F);
    @(negedge clk);
    @(negedge clk);
    chk("fl_refetch_cs", slot_cs, 1);
    chk("fl_refetch_addr", slot_addr, 17'h00099);
    wait_ok(1, 20, cyc);
    chk("fl_refetch_lat", cyc, 4);
    @(posedge clk); #1;
    req_addr[0 +: AW] = 17'h00041;
    req_cs = 2'b11;
    #1;
    chk("fl_p0_invalidated", req_ok[0], 0);
    wait_ok(0, 20, cyc);
    chk("fl_p0_refill", req_dout[0 +: DW], 8'hC7);

    // Flush on the very edge that the fill lands.
    @(posedge clk); #1;
    sd_lat = 2;
    req_addr[0 +: AW] = 17'h000F0;
    req_cs = 2'b01;
    @(negedge clk); @(negedge clk);
    chk("flf_cs_up", slot_cs, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flf_filled", slot_cs, 0);
    chk("flf_ok_low", req_ok[0], 0);
    chk("flf_dout", req_dout[0 +: DW], 8'h76);
    wait_ok(0, 20, cyc);
    chk("flf_refetch_done", cyc > 0, 1);

    // Randomized traffic against the memory + bounded-wait model.
    wc[0] = 0; wc[1] = 0;
    pa[0] = req_addr[0 +: AW];
    pa[1] = req_addr[AW +: AW];
    for (int it = 0; it < 1500; it++) begin
      @(posedge clk); #1;
      if (it % 300 == 0) sd_lat = $urandom_range(1, 4);
      flush = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          req_cs[i] = ($urandom_range(0, 3) != 0);
          req_addr[i*AW +: AW] = 17'h00100 + 17'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req_cs[i] && !req_ok[i] && !flush && req_addr[i*AW +: AW] == pa[i])
          wc[i]++;
        else
          wc[i] = 0;
        pa[i] = req_addr[i*AW +: AW];
        chk($sformatf("rnd_ok_gated_p%0d", i), req_ok[i] & ~req_cs[i], 0);
        if (req_cs[i]) chk($sformatf("rnd_starve_p%0d", i), wc[i] > 32, 0);
      end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    req_cs = 2'b00;

    // Asynchronous reset mid-access.
    sd_lat = 5;
    repeat (12) @(posedge clk);
    #1;
    req_addr[0 +: AW] = 17'h1AAAA;
    req_cs = 2'b01;
    @(negedge clk); @(negedge clk);
    chk("ar_cs_up", slot_cs, 1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_cs_dropped", slot_cs, 0);
    chk("ar_ok_low", req_ok, 0);
    chk("ar_dout_zero", req_dout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ok(0, 20, cyc);
    chk("ar_after_reset_lat", cyc, 8);
    chk("ar_after_reset_dout", req_dout[0 +: DW], 8'h2C);

    chk("data_invariant_bad", dat_bad, 0);
    chk("data_invariant_seen", dat_checks > 0, 1);
    chk("min_cs_high", min_hi >= 2, 1);
    chk("slot_addr_stable", addr_moves, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
